serial_addsub_engine: RTL and testbench

Parametrised bit-serial adder/subtractor with its own control FSM. On a start request it captures two WIDTH-bit operands and a mode bit, then processes one bit per clock, LSB first, using a single full adder and a carry flip-flop. It reports busy and done, with result, carry and signed overflow flags. It replaces the fixed-width controller plus external datapath used by the serial adder/subtractor top level.

---
 rtl/serial_addsub_engine.sv | 136 +++++++++++++
 tb/tb_serial_addsub_engine.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub_engine.sv
// Bit-serial adder/subtractor with its own control FSM.
// A start request in IDLE (or a fresh request after DONE drops to IDLE) captures
// the operands and mode. One bit is then processed per clock, LSB first, through
// a single full adder and a carry flip-flop.
//
// Ports:
//   clock      in   rising-edge clock
//   resetn     in   asynchronous active-low reset
//   start      in   level request, sampled in IDLE and DONE only
//   sub        in   0 = a+b, 1 = a-b (captured at load)
//   a, b       in   WIDTH-bit operands (captured at load)
//   busy       out  high while bits are being processed
//   done       out  high while the result is valid
//   result     out  WIDTH-bit sum/difference
//   carry_out  out  final carry (subtract: 1 = no borrow)
//   overflow   out  two's-complement overflow
module serial_addsub_engine #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWork = 2'b01,
    StDone = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic bb, s, cn;

  // Single full adder; subtract inverts B and seeds the carry with 1.
  assign bb = b_sr_q[0] ^ mode_q;
  assign s  = a_sr_q[0] ^ bb ^ c_q;
  assign cn = (a_sr_q[0] & bb) | (a_sr_q[0] & c_q) | (bb & c_q);

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    c_d      = c_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          a_sr_d   = a;
          b_sr_d   = b;
          mode_d   = sub;
          c_d      = sub;
          cnt_d    = '0;
          result_d = '0;
          cout_d   = 1'b0;
          ovf_d    = 1'b0;
          state_d  = StWork;
        end
      end
      StWork: begin
        result_d = {s, result_q[WIDTH-1:1]};
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        c_d      = cn;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          // Overflow: carry into the MSB differs from carry out of it.
          cout_d  = cn;
          ovf_d   = c_q ^ cn;
          state_d = StDone;
        end
      end
      StDone: begin
        // Leave only once start is seen low, so a held request cannot retrigger.
        if (!start) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      c_q      <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      c_q      <= c_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy      = (state_q == StWork);
  assign done      = (state_q == StDone);
  assign result    = result_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_addsub_engine.sv
// Bench for serial_addsub_engine at WIDTH=8 and WIDTH=16.
module tb_serial_addsub_engine;

  logic clock;
  logic resetn;

  logic        start8, sub8, busy8, done8, cout8, ovf8;
  logic [7:0]  a8, b8, result8;
  logic        start16, sub16, busy16, done16, cout16, ovf16;
  logic [15:0] a16, b16, result16;

  int checks;
  int errors;

  serial_addsub_engine #(.WIDTH(8)) dut8 (
    .clock(clock), .resetn(resetn), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(result8), .carry_out(cout8), .overflow(ovf8)
  );

  serial_addsub_engine #(.WIDTH(16)) dut16 (
    .clock(clock), .resetn(resetn), .start(start16), .sub(sub16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .result(result16), .carry_out(cout16),
    .overflow(ovf16)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    int          w;
    logic [15:0] a;
    logic [15:0] b;
    bit          sub;
    logic [15:0] er;
    bit          ec;
    bit          eo;
    string       name;
  } vec_t;

  typedef struct {
    logic [15:0] r;
    bit          c;
    bit          o;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model(input int w, input logic [15:0] ia, input logic [15:0] ib,
                                input bit s, output logic [15:0] r, output bit c,
                                output bit o);
    logic [16:0] sum;
    logic [15:0] mask, bx;
    mask = (w == 16) ? 16'hFFFF : 16'h00FF;
    bx   = (s ? ~ib : ib) & mask;
    sum  = {1'b0, ia & mask} + {1'b0, bx} + {16'b0, s};
    r    = sum[15:0] & mask;
    c    = sum[w];
    if (s) o = (ia[w-1] != ib[w-1]) && (r[w-1] != ia[w-1]);
    else   o = (ia[w-1] == ib[w-1]) && (r[w-1] != ia[w-1]);
  endfunction

  task automatic drive(input int w, input bit st, input logic [15:0] ia,
                       input logic [15:0] ib, input bit s);
    if (w == 8) begin
      start8 = st; a8 = ia[7:0]; b8 = ib[7:0]; sub8 = s;
    end else begin
      start16 = st; a16 = ia; b16 = ib; sub16 = s;
    end
  endtask

  task automatic sample(input int w, output logic bz, output logic dn, output logic [15:0] r,
                        output logic c, output logic o);
    if (w == 8) begin
      bz = busy8; dn = done8; r = {8'h00, result8}; c = cout8; o = ovf8;
    end else begin
      bz = busy16; dn = done16; r = result16; c = cout16; o = ovf16;
    end
  endtask

  // One operation: push expectation on drive, pop on done. Operands are
  // scrambled after the load edge to show WORK ignores them.
  task automatic run_op(input int w, input logic [15:0] ia, input logic [15:0] ib,
                        input bit s, input logic [15:0] er, input bit ec, input bit eo,
                        input string name, input bit hold);
    exp_t e;
    int n, busy_cnt;
    bit seen, both;
    logic bz, dn, c, o;
    logic [15:0] r;
    @(negedge clock);
    drive(w, 1'b1, ia, ib, s);
    e.r = er; e.c = ec; e.o = eo;
    sb.push_back(e);
    n = 0; busy_cnt = 0; seen = 0; both = 0;
    while (!seen && n < w + 8) begin
      @(negedge clock);
      n++;
      sample(w, bz, dn, r, c, o);
      if (bz) busy_cnt++;
      if (bz && dn) both = 1;
      seen = dn;
      if (n == 1) drive(w, hold, 16'($urandom()), 16'($urandom()), 1'($urandom()));
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no done after %0d cycles, expected at %0d", name, n, w + 1);
      void'(sb.pop_front());
      drive(w, 1'b0, 16'h0, 16'h0, 1'b0);
    end else begin
      e = sb.pop_front();
      chk({name, " result"}, 32'(r), 32'(e.r));
      chk({name, " carry_out"}, 32'(c), 32'(e.c));
      chk({name, " overflow"}, 32'(o), 32'(e.o));
      chk({name, " done latency"}, 32'(n), 32'(w + 1));
      chk({name, " busy cycles"}, 32'(busy_cnt), 32'(w));
      chk({name, " busy&done"}, 32'(both), 32'd0);
      if (hold) begin
        repeat (5) begin
          @(negedge clock);
          sample(w, bz, dn, r, c, o);
          chk({name, " hold done"}, 32'(dn), 32'd1);
          chk({name, " hold busy"}, 32'(bz), 32'd0);
          chk({name, " hold result"}, 32'(r), 32'(er));
        end
        drive(w, 1'b0, 16'h0, 16'h0, 1'b0);
        @(negedge clock);
        sample(w, bz, dn, r, c, o);
        chk({name, " idle done"}, 32'(dn), 32'd0);
        chk({name, " idle busy"}, 32'(bz), 32'd0);
      end
    end
  endtask

  initial begin
    logic [15:0] ra, rb, er;
    bit rs, ec, eo;
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    start8 = 0; sub8 = 0; a8 = '0; b8 = '0;
    start16 = 0; sub16 = 0; a16 = '0; b16 = '0;

    vecs.push_back('{8,  16'h35,   16'h4A,   0, 16'h7F,   0, 0, "add35_4a"});
    vecs.push_back('{8,  16'h7F,   16'h01,   0, 16'h80,   0, 1, "add7f_01"});
    vecs.push_back('{8,  16'hFF,   16'h01,   0, 16'h00,   1, 0, "addff_01"});
    vecs.push_back('{8,  16'h80,   16'h80,   0, 16'h00,   1, 1, "add80_80"});
    vecs.push_back('{8,  16'h10,   16'h01,   1, 16'h0F,   1, 0, "sub10_01"});
    vecs.push_back('{8,  16'h00,   16'h01,   1, 16'hFF,   0, 0, "sub00_01"});
    vecs.push_back('{8,  16'h80,   16'h01,   1, 16'h7F,   1, 1, "sub80_01"});
    vecs.push_back('{16, 16'h7FFF, 16'h0001, 0, 16'h8000, 0, 1, "add7fff_1"});
    vecs.push_back('{16, 16'h1234, 16'h1235, 1, 16'hFFFF, 0, 0, "sub1234_1235"});

    #12;
    chk("reset busy", 32'(busy8), 32'd0);
    chk("reset done", 32'(done8), 32'd0);
    chk("reset result", 32'(result8), 32'd0);
    chk("reset carry", 32'(cout8), 32'd0);
    chk("reset ovf", 32'(ovf8), 32'd0);
    chk("reset result16", 32'(result16), 32'd0);
    @(negedge clock);
    resetn = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].er, vecs[i].ec,
             vecs[i].eo, vecs[i].name, 1'b0);

    // Held start stays in DONE, then a restart after one low cycle works.
    run_op(8, 16'h35, 16'h4A, 0, 16'h7F, 0, 0, "hold", 1'b1);
    run_op(8, 16'h10, 16'h01, 1, 16'h0F, 1, 0, "restart", 1'b0);

    // Asynchronous reset mid-WORK, between clock edges.
    @(negedge clock);
    drive(8, 1'b1, 16'h0F, 16'h00, 1'b0);
    @(negedge clock);
    drive(8, 1'b0, 16'h0F, 16'h00, 1'b0);
    repeat (3) @(negedge clock);
    chk("midwork busy", 32'(busy8), 32'd1);
    chk("midwork partial", 32'(result8), 32'hE0);
    #2 resetn = 1'b0;
    #1;
    chk("async busy", 32'(busy8), 32'd0);
    chk("async done", 32'(done8), 32'd0);
    chk("async result", 32'(result8), 32'd0);
    chk("async carry", 32'(cout8), 32'd0);
    chk("async ovf", 32'(ovf8), 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    run_op(8, 16'h12, 16'h34, 0, 16'h46, 0, 0, "post_reset", 1'b0);

    for (int i = 0; i < 12; i++) begin
      ra = 16'($urandom()); rb = 16'($urandom()); rs = 1'($urandom());
      model(16, ra, rb, rs, er, ec, eo);
      run_op(16, ra, rb, rs, er, ec, eo, "rand16", 1'b0);
    end
    for (int i = 0; i < 12; i++) begin
      ra = 16'($urandom_range(0, 255)); rb = 16'($urandom_range(0, 255));
      rs = 1'($urandom());
      model(8, ra, rb, rs, er, ec, eo);
      run_op(8, ra, rb, rs, er, ec, eo, "rand8", 1'b0);
    end

    chk("scoreboard empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
